rgb_pwm_gen: RTL and testbench
==============================

# rgb_pwm_gen

- Generates the three single-bit PWM streams that feed the RGB LED driver's `RGB0PWM`, `RGB1PWM` and `RGB2PWM` inputs, so LED brightness is set by duty value instead of raw on/off.
- Per-channel duty values are double-buffered and loaded through a one-cycle strobe. They commit only at a PWM period boundary, so there are no glitched partial periods.
- A per-channel gate lets the controller's blink output (active high) switch a channel on and off at its programmed brightness.
- Sits in the top level between the controller and the LED driver, replacing the direct register of the blink output.

## Interface
Parameters:
- `PWM_BITS`, default 8: duty and PWM counter width. Period is 2^PWM_BITS steps.
- `PRESCALE_BITS`, default 4, must be ≥1: each PWM step lasts 2^PRESCALE_BITS clocks.

Ports:
- `i_clk`, in, 1: system clock (48 MHz HFOSC).
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_duty_r`, `i_duty_g`, `i_duty_b`, in, PWM_BITS each: duty values, sampled only when `i_load`=1.
- `i_load`, in, 1: one-cycle strobe that captures all three duties into the shadow registers.
- `i_gate`, in, 3: per-channel enable. Bit 2 = r, bit 1 = g, bit 0 = b. Active high.
- `o_pending`, out, 1: a shadow load is waiting for the period boundary.
- `o_pwm_r`, `o_pwm_g`, `o_pwm_b`, out, 1 each: registered PWM outputs, active high.
- `o_period_start`, out, 1: one-cycle pulse marking the first output cycle of a new period.

## Operation
Prescaler:
- `pre_cnt` counts 0 to 2^PRESCALE_BITS−1 and wraps.
- `tick` = (`pre_cnt` == max).

PWM counter:
- `pwm_cnt` increments on `tick` and wraps from 2^PWM_BITS−1 to 0.
- `boundary` = `tick` && `pwm_cnt` == max.

Compare:
- Next value of `o_pwm_x` = `i_gate[x]` && (`pwm_cnt` < `active_x`).
- Duty 0 gives a constant low output.
- Duty 2^PWM_BITS−1 is high for (2^PWM_BITS−1)/2^PWM_BITS of the period. There is no 100% duty.

Load handshake (two states, IDLE and PENDING, encoded by `o_pending`):
- IDLE and `i_load`: shadow ← `i_duty_*`, go to PENDING.
- PENDING and `i_load` without `boundary`: shadow is overwritten (latest wins), stay in PENDING.
- PENDING and `boundary` without `i_load`: active ← shadow, go to IDLE.
- PENDING and `boundary` and `i_load` together: active ← old shadow, shadow ← new inputs, stay in PENDING. The new values commit at the next boundary.
- `i_load` is never ignored; no ack beyond `o_pending` is required.

Other behaviour:
- `i_gate` is not latched. It affects the output on the cycle after it changes, regardless of the period.
- Reset mid-operation: all state clears on the next edge and any pending load is discarded.

## Timing
- Reset values: `pre_cnt`, `pwm_cnt`, shadow and active duties are 0. `o_pending`, all `o_pwm_*` and `o_period_start` are 0.
- Output latency: `o_pwm_x` reflects `pwm_cnt`, `active_x` and `i_gate` from the previous cycle (one register stage).
- Commit edge: the active-duty update happens on the same edge that `pwm_cnt` wraps to 0. The first output cycle of the new period already uses the new duty.
- `o_period_start` is 1 on exactly the cycle that `o_pwm_*` first reflects `pwm_cnt`=0 after a wrap.
- Immediately after reset release, the counter starts at 0 with no pulse. The first pulse follows the first wrap.
- Period length is 2^(PWM_BITS+PRESCALE_BITS) clocks. High time is duty × 2^PRESCALE_BITS clocks.
- `o_pending` rises the cycle after `i_load`. It falls on the commit edge unless a load coincides with that edge.

## Structure
- Shared package `prewish5k_pkg` holds:
  - the channel index constants `CH_R`=2, `CH_G`=1, `CH_B`=0;
  - the default `PWM_BITS` and `PRESCALE_BITS`.
- Sub-module `pwm_tick_div` contains the prescaler. It has parameter `PRESCALE_BITS`, inputs `i_clk` and `i_reset`, and output `o_tick`.
- Everything else lives in `rgb_pwm_gen`.

## Test plan
All scenarios use `PWM_BITS`=4 and `PRESCALE_BITS`=1, giving a 32-clock period.
- **Reset, no load:** hold `i_gate`=3'b111 for 100 clocks → all `o_pwm_*` stay 0, `o_pending`=0, and `o_period_start` pulses every 32 clocks from the first wrap.
- **Basic load:** load r=4, g=0, b=15 mid-period → `o_pending`=1 until the commit edge; then per 32-clock period r is high 8 clocks, g 0 clocks, b 30 clocks, all starting on the `o_period_start` cycle.
- **Overwrite:** load r=2, then r=9, in the same period → only r=9 (18 clocks high) ever appears, and no period shows 2.
- **Load at boundary:** active r=4, shadow r=6, then `i_load` r=10 on the boundary cycle → next period r=6 (12 clocks) with `o_pending` still 1, following period r=10 (20 clocks) with `o_pending`=0.
- **Gate:** with duty g=8, drop `i_gate[1]` mid-high → `o_pwm_g`=0 the next cycle; raise it again → the pattern resumes in phase, and the duty is unchanged.
- **Reset while pending:** assert `i_reset` while pending with active r=12 → next cycle all outputs and `o_pending` are 0; after release r stays 0 with no late commit.

Source files
------------

// File: rtl/prewish5k_pkg.sv
// Shared definitions for the prewish5k top level.
// - Channel indices used for the per-channel gate bits and duty arrays.
// - Default PWM and prescaler widths.
// - Load handshake state type for rgb_pwm_gen.
package prewish5k_pkg;

    // Gate bit / array index per colour channel
    localparam int unsigned CH_R = 2;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 0;

    localparam int unsigned DEFAULT_PWM_BITS      = 8;
    localparam int unsigned DEFAULT_PRESCALE_BITS = 4;

    // The state bit doubles as the o_pending output
    typedef enum logic {
        StIdle    = 1'b0,
        StPending = 1'b1
    } load_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// PWM step prescaler: free-running counter that wraps every 2^PRESCALE_BITS clocks.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset, clears the counter
//   o_tick  - high on the last clock of each PWM step (counter at its maximum)
module pwm_tick_div #(
    parameter int unsigned PRESCALE_BITS = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_MAX = '1;

    logic [PRESCALE_BITS-1:0] pre_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_cnt_q <= '0;
        end else begin
            // Wraps naturally from max back to 0
            pre_cnt_q <= pre_cnt_q + PRE_ONE;
        end
    end

    assign o_tick = (pre_cnt_q == PRE_MAX);

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator feeding the RGB LED driver's PWM inputs.
// Duties are written to a shadow register by a one-cycle load strobe and
// committed to the active register only at a PWM period boundary.
// Ports:
//   i_clk, i_reset             - clock, synchronous active-high reset
//   i_duty_r/g/b               - duty values, captured when i_load = 1
//   i_load                     - one-cycle strobe capturing all three duties
//   i_gate[2:0]                - per-channel enable (bit 2 = r, 1 = g, 0 = b)
//   o_pending                  - a shadow load waits for the period boundary
//   o_pwm_r/g/b                - registered PWM outputs, active high
//   o_period_start             - pulse on the first output cycle of a new period
module rgb_pwm_gen
    import prewish5k_pkg::*;
#(
    parameter int unsigned PWM_BITS      = DEFAULT_PWM_BITS,
    parameter int unsigned PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [PWM_BITS-1:0] i_duty_r,
    input  logic [PWM_BITS-1:0] i_duty_g,
    input  logic [PWM_BITS-1:0] i_duty_b,
    input  logic                i_load,
    input  logic [2:0]          i_gate,
    output logic                o_pending,
    output logic                o_pwm_r,
    output logic                o_pwm_g,
    output logic                o_pwm_b,
    output logic                o_period_start
);

    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic                     tick;
    logic                     boundary;
    logic [PWM_BITS-1:0]      pwm_cnt_q;
    logic [2:0][PWM_BITS-1:0] duty_in;
    logic [2:0][PWM_BITS-1:0] shadow_q;
    logic [2:0][PWM_BITS-1:0] active_q;
    logic [2:0]               pwm_q;
    logic                     boundary_q;
    logic                     period_start_q;
    load_state_e              state_q;

    pwm_tick_div #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_tick_div (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    always_comb begin
        duty_in       = '0;
        duty_in[CH_R] = i_duty_r;
        duty_in[CH_G] = i_duty_g;
        duty_in[CH_B] = i_duty_b;
    end

    // Last clock of the last step: pwm_cnt wraps on this edge
    assign boundary = tick && (pwm_cnt_q == CNT_MAX);

    // Counter, compare and period-start pipeline
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwm_cnt_q      <= '0;
            pwm_q          <= '0;
            boundary_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + CNT_ONE;
            end
            for (int ch = 0; ch < 3; ch++) begin
                pwm_q[ch] <= i_gate[ch] && (pwm_cnt_q < active_q[ch]);
            end
            // boundary_q marks the cycle pwm_cnt reads 0; the outputs show
            // that count one cycle later, so the pulse is delayed once more.
            boundary_q     <= boundary;
            period_start_q <= boundary_q;
        end
    end

    // Load handshake: shadow captures on every load, active takes the shadow
    // contents held before this edge when a boundary hits while pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_load) begin
                        shadow_q <= duty_in;
                        state_q  <= StPending;
                    end
                end
                StPending: begin
                    if (boundary) begin
                        active_q <= shadow_q;
                    end
                    if (i_load) begin
                        shadow_q <= duty_in;
                    end else if (boundary) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_pending      = (state_q == StPending);
    assign o_pwm_r        = pwm_q[CH_R];
    assign o_pwm_g        = pwm_q[CH_G];
    assign o_pwm_b        = pwm_q[CH_B];
    assign o_period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
module tb_rgb_pwm_gen;

    localparam int PW   = 4;
    localparam int PB   = 1;
    localparam int STEP = 1 << PB;          // clocks per PWM step
    localparam int PER  = 1 << (PW + PB);   // clocks per period

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] d_r, d_g, d_b;
    logic          load;
    logic [2:0]    gate;
    logic          pending, pwm_r, pwm_g, pwm_b, pstart;

    always #5 clk = ~clk;

    rgb_pwm_gen #(
        .PWM_BITS     (PW),
        .PRESCALE_BITS(PB)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_duty_r      (d_r),
        .i_duty_g      (d_g),
        .i_duty_b      (d_b),
        .i_load        (load),
        .i_gate        (gate),
        .o_pending     (pending),
        .o_pwm_r       (pwm_r),
        .o_pwm_g       (pwm_g),
        .o_pwm_b       (pwm_b),
        .o_period_start(pstart)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: clocks since reset release plus the duty bookkeeping.
    // Index 0 = b, 1 = g, 2 = r (matches gate bits).
    int m_k;
    int m_active[3];
    int m_shadow[3];
    bit m_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the next edge, advance one clock, compare.
    task automatic step();
        bit         e_pwm[3];
        bit         e_ps;
        bit         bnd;
        int         cnt;
        int         din[3];
        logic [4:0] exp_v;
        e_pwm = '{0, 0, 0};
        e_ps  = 0;
        if (rst) begin
            m_k = 0;
            m_pending = 0;
            for (int c = 0; c < 3; c++) begin
                m_active[c] = 0;
                m_shadow[c] = 0;
            end
        end else begin
            din[0] = int'(d_b);
            din[1] = int'(d_g);
            din[2] = int'(d_r);
            cnt = (m_k / STEP) % (1 << PW);
            for (int c = 0; c < 3; c++) e_pwm[c] = gate[c] && (cnt < m_active[c]);
            e_ps = (m_k % PER == 0) && (m_k >= PER);
            bnd  = (m_k % PER) == PER - 1;
            if (m_pending && bnd) begin
                for (int c = 0; c < 3; c++) m_active[c] = m_shadow[c];
                m_pending = 0;
            end
            if (load) begin
                for (int c = 0; c < 3; c++) m_shadow[c] = din[c];
                m_pending = 1;
            end
            m_k++;
        end
        exp_v = {m_pending, e_pwm[2], e_pwm[1], e_pwm[0], e_ps};
        @(posedge clk);
        #1;
        check("outputs", {pending, pwm_r, pwm_g, pwm_b, pstart}, exp_v);
    endtask

    task automatic load_duties(input int r, input int g, input int b);
        d_r  = PW'(r);
        d_g  = PW'(g);
        d_b  = PW'(b);
        load = 1'b1;
        step();
        load = 1'b0;
        d_r  = PW'($urandom);
        d_g  = PW'($urandom);
        d_b  = PW'($urandom);
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            if (pstart) break;
        end
        check("period_start_seen", pstart, 1);
    endtask

    task automatic advance_to(input int phase);
        for (int i = 0; i < PER; i++) begin
            if (m_k % PER == phase) break;
            step();
        end
    endtask

    // Counts the high clocks of a period whose first cycle is the current one
    task automatic count_rest(input int er, input int eg, input int eb);
        int cr, cg, cb;
        cr = int'(pwm_r);
        cg = int'(pwm_g);
        cb = int'(pwm_b);
        for (int i = 1; i < PER; i++) begin
            step();
            cr += int'(pwm_r);
            cg += int'(pwm_g);
            cb += int'(pwm_b);
        end
        check("high_clocks_r", cr, er);
        check("high_clocks_g", cg, eg);
        check("high_clocks_b", cb, eb);
    endtask

    task automatic measure(input int er, input int eg, input int eb);
        wait_ps();
        count_rest(er, eg, eb);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        gate = 3'b111;
        d_r  = '0;
        d_g  = '0;
        d_b  = '0;
        repeat (3) step();
        check("rst_pending", pending, 0);
        check("rst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
        check("rst_pstart", pstart, 0);
        rst = 1'b0;

        // Reset, no load: outputs low, period_start every PER clocks
        repeat (100) step();

        // Basic load mid-period
        advance_to(10);
        load_duties(4, 0, 15);
        check("pending_after_load", pending, 1);
        measure(8, 0, 30);
        check("pending_after_commit", pending, 0);

        // Overwrite within one period: only the later value appears
        wait_ps();
        repeat (3) step();
        load_duties(2, 0, 15);
        step();
        step();
        load_duties(9, 0, 15);
        measure(18, 0, 30);

        // Load coinciding with the boundary
        load_duties(4, 0, 15);
        measure(8, 0, 30);
        advance_to(5);
        load_duties(6, 0, 15);
        advance_to(PER - 1);
        load_duties(10, 0, 15);
        wait_ps();
        check("pending_held_boundary", pending, 1);
        count_rest(12, 0, 15 * STEP);
        measure(20, 0, 30);
        check("pending_cleared", pending, 0);

        // Gate drop and restore
        load_duties(10, 8, 15);
        measure(20, 16, 30);
        wait_ps();
        repeat (3) step();
        gate = 3'b101;
        step();
        check("gate_off_g", pwm_g, 0);
        repeat (4) step();
        gate = 3'b111;
        step();
        check("gate_on_g", pwm_g, 1);
        measure(20, 16, 30);

        // Reset while a load is pending
        load_duties(12, 8, 15);
        measure(24, 16, 30);
        repeat (5) step();
        load_duties(3, 3, 3);
        step();
        rst = 1'b1;
        step();
        check("rst_mid_pending", pending, 0);
        check("rst_mid_pwm", {pwm_r, pwm_g, pwm_b}, 0);
        check("rst_mid_pstart", pstart, 0);
        rst = 1'b0;
        repeat (40) step();
        measure(0, 0, 0);

        // Randomised loads and gate changes against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) gate = 3'($urandom);
            if ($urandom_range(19) == 0) begin
                load_duties(int'($urandom_range(15)), int'($urandom_range(15)),
                            int'($urandom_range(15)));
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
